// File: rtl/fifo_rd_stream.sv
// Streams words from a show-ahead-less FIFO read port into a valid/ready interface through a 2-entry skid buffer.
// Optional transfer counter port xfer_cnt is enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic             inflight;
  logic             pop;
  logic             capture;
  logic [1:0]       occ;
  logic [1:0]       load;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    occ        = 2'd0;
    state_next = state;
    unique case (state)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase

    m_valid = (state != EMPTY);
    m_data  = mem[head];
    pop     = m_valid && m_ready;
    capture = inflight && !flush;

    // Words already held plus the one on its way, minus the one leaving now, must leave room.
    load      = occ + {1'b0, inflight} - {1'b0, pop};
    fifo_read = rst && !fifo_empty && !flush && (load < 2'd2);

    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (capture) state_next = ONE;
        ONE: begin
          if (capture && !pop)      state_next = TWO;
          else if (!capture && pop) state_next = EMPTY;
        end
        TWO:     if (pop && !capture) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: the two storage entries are reset because m_data must read 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same pre-edge values.
      state    <= state_next;
      inflight <= fifo_read;
      if (flush) begin
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (capture) begin
          mem[tail] <= fifo_data;
          tail      <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  // Counts consumer handshakes only; flush drops words but never touches the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     xfer_cnt <= 16'd0;
    else if (pop) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule
